reg_joiner: RTL

- Receive-side counterpart of the register splitter.
- Takes a stream of 8-bit bytes, each qualified by a one-cycle strobe, and reassembles them into 32-bit ADC register words, most-significant byte first.
- Holds each completed word for the consumer behind a valid/read handshake.
- An inter-byte timeout resynchronises the block to word boundaries after a dropped byte.

---
 rtl/reg_joiner.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_joiner.sv
// Byte-stream to word reassembler: collects BYTES bytes MSB-first into one word,
// presents it behind a valid/read handshake, and drops stale partial words on an inter-byte timeout.
module reg_joiner #(
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [7:0]           register,
  input  logic                 clear,
  input  logic                 read,
  output logic [8*BYTES-1:0]   adcReg,
  output logic                 adcValid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeoutErr,
  output logic [7:0]           errCount
);

  localparam int              W        = 8 * BYTES;
  localparam int              IW       = (BYTES > 1) ? $clog2(BYTES + 1) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(BYTES);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt, w_idx_inc;
  logic [15:0]     r_timer;
  logic [W-1:0]    r_shreg, w_shift;
  logic            w_accept, w_complete, w_timeout;

  // clear wins over a simultaneous strobe, so that byte never counts as accepted
  assign w_accept   = enable & ~clear;
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_complete = w_accept & (w_idx_inc == LAST_IDX);
  assign w_timeout  = ~clear & ~enable & (r_state == COLLECT) & (r_timer == TMO_LAST);
  assign busy       = (r_state == COLLECT);

  generate
    if (BYTES == 1) begin : g_one
      assign w_shift = register;
    end else begin : g_multi
      assign w_shift = {r_shreg[W-9:0], register};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (clear) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else if (w_accept) begin
      if (w_complete) begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end else begin
        w_state_nxt = COLLECT;
        w_idx_nxt   = w_idx_inc;
      end
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end
  end

  // Stage p0: byte index, idle timer and word/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_timer    <= '0;
      adcReg     <= '0;
      adcValid   <= 1'b0;
      overrun    <= 1'b0;
      timeoutErr <= 1'b0;
      errCount   <= '0;
    end else begin
      r_idx      <= w_idx_nxt;
      timeoutErr <= w_timeout;
      if (clear || w_accept || w_timeout || r_state != COLLECT) r_timer <= '0;
      else                                                      r_timer <= r_timer + 16'd1;
      if (w_complete) begin
        adcReg   <= w_shift;
        adcValid <= 1'b1;
        if (adcValid && !read) overrun <= 1'b1;
      end else if (read) begin
        adcValid <= 1'b0;
      end
      if (w_timeout && errCount != 8'hFF) errCount <= errCount + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_shreg <= w_shift;
  end

endmodule
